i2c_req_arbiter: RTL and testbench

- Sits between several command sources (AXI register slave, debug/start logic) and the single I2C master byte engine that drives `scl_o`/`sda_io`.
- Accepts one single-byte transaction per requester through a valid/ready handshake and grants the engine round-robin.
- Launches each transaction, waits for completion under a watchdog, and returns read data and status to the owning requester.

---
 rtl/i2c_req_arbiter.sv | 137 +++++++++++++
 tb/tb_i2c_req_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master byte engine among NUM_REQ command sources.
// Each grant launches one engine transaction under a watchdog and routes the response back.
module i2c_req_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [7*NUM_REQ-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]     req_rw_i,
  input  logic [8*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [7:0]             rsp_rdata_o,
  output logic                   rsp_nack_o,
  output logic                   rsp_timeout_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   mst_start_o,
  output logic [6:0]             mst_addr_o,
  output logic                   mst_rw_o,
  output logic [7:0]             mst_wdata_o,
  output logic                   mst_abort_o,
  input  logic                   mst_done_i,
  input  logic [7:0]             mst_rdata_i,
  input  logic                   mst_nack_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ABORT  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   w_cand [NUM_REQ];
  logic [PTR_W-1:0]   w_sel;
  logic               w_any;

  // Candidate order starts at the round-robin pointer and wraps
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_cand[i] = PTR_W'((int'(r_ptr) + i) % int'(NUM_REQ));
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_any && req_valid_i[w_cand[i]]) begin
        w_any = 1'b1;
        w_sel = w_cand[i];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && r_state == S_IDLE && w_any) begin
      req_ready_o[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      rsp_valid_o   <= '0;
      rsp_rdata_o   <= '0;
      rsp_nack_o    <= 1'b0;
      rsp_timeout_o <= 1'b0;
      grant_o       <= '0;
      mst_start_o   <= 1'b0;
      mst_addr_o    <= '0;
      mst_rw_o      <= 1'b0;
      mst_wdata_o   <= '0;
      mst_abort_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            mst_addr_o  <= req_addr_i[int'(w_sel)*7 +: 7];
            mst_rw_o    <= req_rw_i[w_sel];
            mst_wdata_o <= req_wdata_i[int'(w_sel)*8 +: 8];
            mst_start_o <= 1'b1;
            grant_o     <= req_ready_o;
            r_ptr       <= (w_sel == PTR_W'(NUM_REQ - 1)) ? '0 : w_sel + PTR_W'(1);
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          mst_start_o <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Completion takes priority over a watchdog expiry in the same cycle
          if (mst_done_i) begin
            rsp_rdata_o   <= mst_rw_o ? mst_rdata_i : 8'h00;
            rsp_nack_o    <= mst_nack_i;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= grant_o;
            r_state       <= S_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            mst_abort_o <= 1'b1;
            r_state     <= S_ABORT;
          end
        end
        S_ABORT: begin
          mst_abort_o   <= 1'b0;
          rsp_rdata_o   <= 8'h00;
          rsp_nack_o    <= 1'b0;
          rsp_timeout_o <= 1'b1;
          rsp_valid_o   <= grant_o;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_o <= '0;
          grant_o     <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: two requesters, 8-cycle watchdog, hand-computed expectations.
module tb_i2c_req_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TO      = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [7*NUM_REQ-1:0] req_addr_i;
  logic [NUM_REQ-1:0]   req_rw_i;
  logic [8*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]   rsp_valid_o;
  logic [7:0]           rsp_rdata_o;
  logic                 rsp_nack_o;
  logic                 rsp_timeout_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 mst_start_o;
  logic [6:0]           mst_addr_o;
  logic                 mst_rw_o;
  logic [7:0]           mst_wdata_o;
  logic                 mst_abort_o;
  logic                 mst_done_i;
  logic [7:0]           mst_rdata_i;
  logic                 mst_nack_i;

  int vectors = 0;
  int miscompares = 0;

  i2c_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_rw_i(req_rw_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_nack_o(rsp_nack_o),
    .rsp_timeout_o(rsp_timeout_o), .grant_o(grant_o),
    .mst_start_o(mst_start_o), .mst_addr_o(mst_addr_o), .mst_rw_o(mst_rw_o),
    .mst_wdata_o(mst_wdata_o), .mst_abort_o(mst_abort_o),
    .mst_done_i(mst_done_i), .mst_rdata_i(mst_rdata_i), .mst_nack_i(mst_nack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr_i[7*k +: 7] = a;
    req_rw_i[k]          = rw;
    req_wdata_i[8*k +: 8] = wd;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = '0;
    tick(); tick();
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
    vectors++; if ({mst_start_o, mst_abort_o, mst_rw_o} !== 3'b000) begin miscompares++; $display("FAIL reset_mst_ctl: got %b want 000", {mst_start_o, mst_abort_o, mst_rw_o}); end
    vectors++; if ({mst_addr_o, mst_wdata_o} !== 15'h0) begin miscompares++; $display("FAIL reset_mst_data: got %h want 0", {mst_addr_o, mst_wdata_o}); end
    vectors++; if ({rsp_rdata_o, rsp_nack_o, rsp_timeout_o} !== 10'h0) begin miscompares++; $display("FAIL reset_rsp: got %h want 0", {rsp_rdata_o, rsp_nack_o, rsp_timeout_o}); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 7'h50, 1'b0, 8'h3C); req_valid_i = 2'b01;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL wr_ready: got %b want 01", req_ready_o); end
    tick(); req_valid_i = '0;
    vectors++; if (mst_start_o !== 1'b1) begin miscompares++; $display("FAIL wr_start: got %b want 1", mst_start_o); end
    vectors++; if (mst_addr_o !== 7'h50) begin miscompares++; $display("FAIL wr_addr: got %h want 50", mst_addr_o); end
    vectors++; if (mst_wdata_o !== 8'h3C) begin miscompares++; $display("FAIL wr_wdata: got %h want 3c", mst_wdata_o); end
    vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL wr_grant: got %b want 01", grant_o); end
    tick();
    vectors++; if (mst_start_o !== 1'b0) begin miscompares++; $display("FAIL wr_start_pulse: got %b want 0", mst_start_o); end
    tick(); tick(); tick();
    tick(); mst_done_i = 1'b1; mst_rdata_i = 8'h77; mst_nack_i = 1'b0;
    tick(); mst_done_i = 1'b0; mst_rdata_i = 8'h00;
    vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid_o); end
    vectors++; if (rsp_rdata_o !== 8'h00) begin miscompares++; $display("FAIL wr_rdata_zero: got %h want 00", rsp_rdata_o); end
    vectors++; if ({rsp_nack_o, rsp_timeout_o} !== 2'b00) begin miscompares++; $display("FAIL wr_status: got %b want 00", {rsp_nack_o, rsp_timeout_o}); end
    tick();
    vectors++; if ({rsp_valid_o, grant_o} !== 4'b0000) begin miscompares++; $display("FAIL wr_idle: got %b want 0000", {rsp_valid_o, grant_o}); end
  endtask

  task automatic test_read();
    set_req(1, 7'h21, 1'b1, 8'h00); req_valid_i = 2'b10;
    #1;
    vectors++; if (req_ready_o !== 2'b10) begin miscompares++; $display("FAIL rd_ready: got %b want 10", req_ready_o); end
    tick(); req_valid_i = '0;
    vectors++; if ({grant_o, mst_rw_o, mst_addr_o} !== {2'b10, 1'b1, 7'h21}) begin miscompares++; $display("FAIL rd_launch: got %h want %h", {grant_o, mst_rw_o, mst_addr_o}, {2'b10, 1'b1, 7'h21}); end
    tick(); mst_done_i = 1'b1; mst_rdata_i = 8'hA5;
    tick(); mst_done_i = 1'b0; mst_rdata_i = 8'h00;
    vectors++; if (rsp_valid_o !== 2'b10) begin miscompares++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid_o); end
    vectors++; if (rsp_rdata_o !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata: got %h want a5", rsp_rdata_o); end
    tick();
    vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL rd_rsp_pulse: got %b want 00", rsp_valid_o); end
    tick(); tick(); tick();
    vectors++; if (rsp_rdata_o !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata_hold: got %h want a5", rsp_rdata_o); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    rst_i = 1'b1;
    set_req(0, 7'h11, 1'b0, 8'h01); set_req(1, 7'h22, 1'b0, 8'h02); req_valid_i = 2'b11;
    tick(); rst_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      vectors++; if (req_ready_o !== exp) begin miscompares++; $display("FAIL fair_ready_%0d: got %b want %b", i, req_ready_o, exp); end
      tick();
      vectors++; if ({req_ready_o, grant_o} !== {2'b00, exp}) begin miscompares++; $display("FAIL fair_grant_%0d: got %b want %b", i, {req_ready_o, grant_o}, {2'b00, exp}); end
      tick(); mst_done_i = 1'b1;
      tick(); mst_done_i = 1'b0;
      if (i == 3) req_valid_i = '0;
      vectors++; if ({req_ready_o, rsp_valid_o} !== {2'b00, exp}) begin miscompares++; $display("FAIL fair_rsp_%0d: got %b want %b", i, {req_ready_o, rsp_valid_o}, {2'b00, exp}); end
      tick();
    end
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL fair_end_ready: got %b want 00", req_ready_o); end
  endtask

  task automatic test_nack();
    set_req(0, 7'h33, 1'b0, 8'h44); req_valid_i = 2'b01;
    tick(); req_valid_i = '0;
    tick(); mst_done_i = 1'b1; mst_nack_i = 1'b1;
    tick(); mst_done_i = 1'b0; mst_nack_i = 1'b0;
    vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL nack_rsp_valid: got %b want 01", rsp_valid_o); end
    vectors++; if ({rsp_nack_o, rsp_timeout_o} !== 2'b10) begin miscompares++; $display("FAIL nack_status: got %b want 10", {rsp_nack_o, rsp_timeout_o}); end
    tick();
  endtask

  task automatic test_timeout();
    set_req(0, 7'h10, 1'b0, 8'h99); req_valid_i = 2'b01;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL to_ready: got %b want 01", req_ready_o); end
    tick(); req_valid_i = '0;
    vectors++; if (mst_start_o !== 1'b1) begin miscompares++; $display("FAIL to_start: got %b want 1", mst_start_o); end
    for (int c = 2; c <= int'(TO) + 1; c++) begin
      tick();
      vectors++; if (mst_abort_o !== 1'b0) begin miscompares++; $display("FAIL to_early_abort_T%0d: got %b want 0", c, mst_abort_o); end
    end
    tick();
    vectors++; if ({mst_abort_o, rsp_valid_o} !== 3'b100) begin miscompares++; $display("FAIL to_abort: got %b want 100", {mst_abort_o, rsp_valid_o}); end
    tick();
    vectors++; if ({mst_abort_o, rsp_valid_o} !== 3'b001) begin miscompares++; $display("FAIL to_rsp: got %b want 001", {mst_abort_o, rsp_valid_o}); end
    vectors++; if ({rsp_timeout_o, rsp_nack_o, rsp_rdata_o} !== 10'b10_0000_0000) begin miscompares++; $display("FAIL to_status: got %b want 1000000000", {rsp_timeout_o, rsp_nack_o, rsp_rdata_o}); end
    tick();
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL to_idle_grant: got %b want 00", grant_o); end
    // Completion lands on the last watchdog cycle
    set_req(0, 7'h12, 1'b1, 8'h00); req_valid_i = 2'b01;
    tick(); req_valid_i = '0;
    for (int c = 2; c <= int'(TO); c++) tick();
    tick(); mst_done_i = 1'b1; mst_rdata_i = 8'h5A;
    tick(); mst_done_i = 1'b0; mst_rdata_i = 8'h00;
    vectors++; if ({mst_abort_o, rsp_valid_o, rsp_timeout_o} !== 4'b0010) begin miscompares++; $display("FAIL edge_rsp: got %b want 0010", {mst_abort_o, rsp_valid_o, rsp_timeout_o}); end
    vectors++; if (rsp_rdata_o !== 8'h5A) begin miscompares++; $display("FAIL edge_rdata: got %h want 5a", rsp_rdata_o); end
    tick();
    vectors++; if ({mst_abort_o, grant_o} !== 3'b000) begin miscompares++; $display("FAIL edge_no_abort: got %b want 000", {mst_abort_o, grant_o}); end
  endtask

  task automatic test_done_ignored();
    mst_done_i = 1'b1; mst_rdata_i = 8'hEE; mst_nack_i = 1'b1;
    tick(); mst_done_i = 1'b0; mst_rdata_i = 8'h00; mst_nack_i = 1'b0;
    tick();
    vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL idle_done_rsp: got %b want 00", rsp_valid_o); end
    vectors++; if ({rsp_rdata_o, rsp_nack_o} !== {8'h5A, 1'b0}) begin miscompares++; $display("FAIL idle_done_hold: got %h want %h", {rsp_rdata_o, rsp_nack_o}, {8'h5A, 1'b0}); end
  endtask

  task automatic test_reset_mid_wait();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    set_req(0, 7'h7F, 1'b1, 8'hFF); req_valid_i = 2'b01;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL rst_pre_ready: got %b want 01", req_ready_o); end
    tick(); req_valid_i = '0;
    tick(); tick(); tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    vectors++; if ({grant_o, rsp_valid_o, req_ready_o} !== 6'b0) begin miscompares++; $display("FAIL rst_mid_handshake: got %b want 000000", {grant_o, rsp_valid_o, req_ready_o}); end
    vectors++; if ({mst_start_o, mst_abort_o, mst_rw_o, mst_addr_o, mst_wdata_o} !== 18'h0) begin miscompares++; $display("FAIL rst_mid_mst: got %h want 0", {mst_start_o, mst_abort_o, mst_rw_o, mst_addr_o, mst_wdata_o}); end
    vectors++; if ({rsp_rdata_o, rsp_nack_o, rsp_timeout_o} !== 10'h0) begin miscompares++; $display("FAIL rst_mid_rsp: got %h want 0", {rsp_rdata_o, rsp_nack_o, rsp_timeout_o}); end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL rst_mid_no_rsp_%0d: got %b want 00", c, rsp_valid_o); end
    end
    req_valid_i = 2'b11;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL rst_post_ptr: got %b want 01", req_ready_o); end
    req_valid_i = '0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_rw_i = '0; req_wdata_i = '0;
    mst_done_i = 1'b0; mst_rdata_i = '0; mst_nack_i = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_fairness();
    test_nack();
    test_timeout();
    test_done_ignored();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
